// File: rtl/div_clk_multi_pkg.sv
// Shared definitions for the multi-channel clock/tick divider: mode encoding
// and default widths/divisor used by the channel and the top.
package div_clk_multi_pkg;

    typedef enum logic {
        DIV_MODE_TOGGLE = 1'b0,
        DIV_MODE_TICK   = 1'b1
    } div_mode_e;

    localparam int DIV_DEF_CNT_W = 32;
    localparam int DIV_DEF_DIV   = 75;

endpackage

// File: rtl/div_clk_multi_chan.sv
// One divider channel: counter, shadow divisor, and the registered toggle
// clock and tick outputs.
module div_chan
    import div_clk_multi_pkg::*;
#(
    parameter int CNT_W   = DIV_DEF_CNT_W,
    parameter int DEF_DIV = DIV_DEF_DIV
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sync_clr,
    input  logic             en,
    input  logic             mode,
    input  logic [CNT_W-1:0] div_val,
    output logic             clk_out,
    output logic             tick_out
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow;
    logic             terminal;

    assign terminal = (cnt == shadow);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the async reset clears outputs without waiting for a clock.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            shadow   <= RESET_DIV;
            clk_out  <= 1'b0;
            tick_out <= 1'b0;
        end else if (sync_clr) begin
            cnt      <= '0;
            shadow   <= div_val;
            clk_out  <= 1'b0;
            tick_out <= 1'b0;
        end else if (!en) begin
            // A stopped channel takes a new divisor at once; cnt and clk_out hold.
            shadow   <= div_val;
            tick_out <= 1'b0;
        end else if (terminal) begin
            cnt      <= '0;
            shadow   <= div_val;
            if (div_mode_e'(mode) == DIV_MODE_TOGGLE) begin
                clk_out <= ~clk_out;
            end
            tick_out <= (div_mode_e'(mode) == DIV_MODE_TICK);
        end else begin
            cnt      <= cnt + CNT_ONE;
            tick_out <= 1'b0;
        end
    end

endmodule

// File: rtl/div_clk_multi.sv
// N-channel programmable clock/tick divider: one div_chan per channel, each
// fed its own slice of the packed divisor bus.
module div_clk_multi
    import div_clk_multi_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = DIV_DEF_CNT_W,
    parameter int DEF_DIV = DIV_DEF_DIV
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  sync_clr,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH-1:0]       mode,
    input  logic [N_CH*CNT_W-1:0] div_val,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       tick_out
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk_in   (clk_in),
            .reset    (reset),
            .sync_clr (sync_clr),
            .en       (en[i]),
            .mode     (mode[i]),
            .div_val  (div_val[i*CNT_W +: CNT_W]),
            .clk_out  (clk_out[i]),
            .tick_out (tick_out[i])
        );
    end

endmodule

// File: tb/tb_div_clk_multi.sv
// Self-checking bench for div_clk_multi: directed edge-count sequences, a
// per-cycle vector table, and a randomized run against a period-based model.
module tb_div_clk_multi;

    localparam int N_CH    = 4;
    localparam int CNT_W   = 32;
    localparam int DEF_DIV = 75;

    logic                  clk_in = 1'b0;
    logic                  reset;
    logic                  sync_clr;
    logic [N_CH-1:0]       en;
    logic [N_CH-1:0]       mode;
    logic [N_CH*CNT_W-1:0] div_val;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       tick_out;

    int total = 0;
    int bad   = 0;

    div_clk_multi #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .sync_clr (sync_clr),
        .en       (en),
        .mode     (mode),
        .div_val  (div_val),
        .clk_out  (clk_out),
        .tick_out (tick_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       sync_clr;
        logic       en;
        logic       mode;
        int         div;
        logic       exp_clk;
        logic       exp_tick;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after each rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_div(input int ch, input int d);
        div_val[ch*CNT_W +: CNT_W] = CNT_W'(d);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        sync_clr = 1'b0;
        en       = '0;
        mode     = '0;
        for (int i = 0; i < N_CH; i++) set_div(i, DEF_DIV);
        #7;
        check("reset_clk_out", clk_out, 0);
        check("reset_tick_out", tick_out, 0);
        @(negedge clk_in);
        reset = 1'b0;
        @(posedge clk_in);
        #1;
        // One edge has elapsed with en=0, so cnt is still 0 after release.
    endtask

    // Count rising edges until the selected output reaches lvl; -1 on timeout.
    task automatic wait_level(input int ch, input bit use_tick, input logic lvl,
                              input int limit, output int n);
        n = 0;
        while (1) begin
            step();
            n++;
            if ((use_tick ? tick_out[ch] : clk_out[ch]) == lvl) return;
            if (n >= limit) begin
                n = -1;
                return;
            end
        end
    endtask

    // Behavioural model: each channel tracks edges elapsed in the current
    // period and the period length (divisor + 1).
    int   m_elapsed [N_CH];
    int   m_period  [N_CH];
    logic m_clk     [N_CH];
    logic m_tick    [N_CH];
    int   cur_div   [N_CH];

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_elapsed[i] = 0;
            m_period[i]  = DEF_DIV + 1;
            m_clk[i]     = 1'b0;
            m_tick[i]    = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < N_CH; i++) begin
            if (sync_clr) begin
                m_elapsed[i] = 0;
                m_period[i]  = cur_div[i] + 1;
                m_clk[i]     = 1'b0;
                m_tick[i]    = 1'b0;
            end else if (!en[i]) begin
                m_period[i] = cur_div[i] + 1;
                m_tick[i]   = 1'b0;
            end else if (m_elapsed[i] + 1 == m_period[i]) begin
                m_elapsed[i] = 0;
                m_period[i]  = cur_div[i] + 1;
                if (mode[i]) m_tick[i] = 1'b1;
                else begin
                    m_clk[i]  = ~m_clk[i];
                    m_tick[i] = 1'b0;
                end
            end else begin
                m_elapsed[i]++;
                m_tick[i] = 1'b0;
            end
        end
    endtask

    vec_t vecs [16];

    initial begin
        int n, n0, n1;
        logic [N_CH-1:0] exp_c, exp_t;

        // Channel 2 cycle-by-cycle sequence: tick with D=2, enable gap, D=0 in both modes.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};

        // Default divisor latency and toggle period.
        do_reset();
        en[0] = 1'b1;
        wait_level(0, 1'b0, 1'b1, 200, n);
        check("def_first_rise_edge", n, 76);
        check("def_tick_idle_mode0", tick_out[0], 0);
        wait_level(0, 1'b0, 1'b0, 200, n);
        check("def_fall_after_rise", n, 76);

        // Divisor written mid-period only governs the period after the terminal count.
        do_reset();
        en[0] = 1'b1;
        repeat (20) step();
        set_div(0, 10);
        wait_level(0, 1'b0, 1'b1, 200, n);
        check("midwrite_rise_edge", n, 56);
        wait_level(0, 1'b0, 1'b0, 200, n);
        check("midwrite_half1", n, 11);
        wait_level(0, 1'b0, 1'b1, 200, n);
        check("midwrite_half2", n, 11);

        // Enable gap holds the count; then async reset mid-cycle.
        do_reset();
        en[0] = 1'b1;
        repeat (30) step();
        en[0] = 1'b0;
        repeat (50) step();
        check("gap_clk_hold", clk_out[0], 0);
        en[0] = 1'b1;
        wait_level(0, 1'b0, 1'b1, 200, n);
        check("gap_resume_edges", n, 46);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_clk", clk_out, 0);
        check("async_reset_tick", tick_out, 0);
        reset = 1'b0;

        // sync_clr realigns out-of-phase tick channels.
        do_reset();
        mode = 4'b0011;
        set_div(0, 5);
        set_div(1, 7);
        step();
        en = 4'b0011;
        repeat (13) step();
        sync_clr = 1'b1;
        step();
        check("sync_clr_clk", clk_out, 0);
        check("sync_clr_tick", tick_out, 0);
        sync_clr = 1'b0;
        n0 = -1;
        n1 = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (n0 < 0 && tick_out[0]) n0 = k;
            if (n1 < 0 && tick_out[1]) n1 = k;
        end
        check("sync_first_tick_ch0", n0, 6);
        check("sync_first_tick_ch1", n1, 8);

        // Vector table on channel 2.
        do_reset();
        for (int v = 0; v < 16; v++) begin
            sync_clr = vecs[v].sync_clr;
            en[2]    = vecs[v].en;
            mode[2]  = vecs[v].mode;
            set_div(2, vecs[v].div);
            step();
            check($sformatf("vec%0d_clk", v), clk_out[2], vecs[v].exp_clk);
            check($sformatf("vec%0d_tick", v), tick_out[2], vecs[v].exp_tick);
        end
        sync_clr = 1'b0;

        // Randomized run against the model.
        do_reset();
        model_reset();
        for (int i = 0; i < N_CH; i++) begin
            cur_div[i] = $urandom_range(0, 7);
            set_div(i, cur_div[i]);
            mode[i] = 1'($urandom_range(0, 1));
        end
        en       = '1;
        sync_clr = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) sync_clr = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N_CH; i++) begin
                en[i] = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 49) == 0) mode[i] = ~mode[i];
                if (en[i] && $urandom_range(0, 39) == 0) begin
                    cur_div[i] = $urandom_range(0, 7);
                    set_div(i, cur_div[i]);
                end
            end
            step();
            model_edge();
            for (int i = 0; i < N_CH; i++) begin
                exp_c[i] = m_clk[i];
                exp_t[i] = m_tick[i];
            end
            check($sformatf("rand%0d_clk", c), clk_out, exp_c);
            check($sformatf("rand%0d_tick", c), tick_out, exp_t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
